trace_retire_reader: RTL and testbench

Consumer end of the instruction trace. Samples the write-back stage's traced instruction word each cycle and records every retired, non-bubble instruction into a FIFO tagged with a retire sequence number. Hands entries to a debug/difftest reader over a valid/ready interface. Detects retirement of `ebreak` to drive a halt/drain/done sequence. Sits beside the pipeline, fed by the W-stage trace output and its valid strobe.

---
 rtl/trace_retire_reader.sv | 102 ++++++++++
 tb/tb_trace_retire_reader.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/trace_retire_reader.sv
// trace_retire_reader: captures retired, non-bubble W-stage instruction words
// into a sequence-tagged FIFO for a debug reader, and runs a halt/drain/done
// sequence once the halt instruction retires.
module trace_retire_reader #(
    parameter int          DEPTH      = 8,
    parameter logic [31:0] HALT_INSTR = 32'h00100073
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [31:0]                instr_W_TR,
    input  logic                       valid_W,
    output logic                       tr_valid,
    input  logic                       tr_ready,
    output logic [31:0]                tr_instr,
    output logic [31:0]                tr_seq,
    output logic [31:0]                retire_cnt,
    output logic [15:0]                drop_cnt,
    output logic                       overflow,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       halted,
    output logic                       done
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {RUN, DRAIN, FIN} state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] seq;
    } entry_t;

    state_t        state;
    entry_t        mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   level_nxt;
    logic          full;
    logic          pop;
    logic          ev;
    logic          push;
    logic          drop;

    // Head data comes straight from storage; tr_valid is purely registered level.
    assign tr_valid = (level != '0);
    assign tr_instr = mem[rd_ptr].instr;
    assign tr_seq   = mem[rd_ptr].seq;
    assign halted   = (state != RUN);
    assign done     = (state == FIN);

    assign full = (level == DEPTH[AW:0]);
    assign pop  = tr_valid && tr_ready;
    assign ev   = valid_W && (instr_W_TR != 32'h0) && (state == RUN);
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign push = ev && (!full || pop);
    assign drop = ev && full && !pop;

    // Occupancy after this cycle's push/pop; also drives the DRAIN->FIN decision.
    always_comb begin
        level_nxt = level;
        if (push && !pop)
            level_nxt = level + 1'b1;
        else if (!push && pop)
            level_nxt = level - 1'b1;
    end

    // Entry storage; contents are don't-care after reset so no reset here.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= '{instr: instr_W_TR, seq: retire_cnt};
    end

    // Pointers, counters, flags and the halt state machine.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            retire_cnt <= '0;
            drop_cnt   <= '0;
            overflow   <= 1'b0;
            state      <= RUN;
        end else begin
            level <= level_nxt;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (ev)
                retire_cnt <= retire_cnt + 32'd1;
            if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != 16'hFFFF)
                    drop_cnt <= drop_cnt + 16'd1;
            end
            case (state)
                RUN:     if (ev && instr_W_TR == HALT_INSTR) state <= DRAIN;
                DRAIN:   if (level_nxt == '0) state <= FIN;
                default: state <= FIN;
            endcase
        end
    end
endmodule

// File: tb/tb_trace_retire_reader.sv
// Directed bench for trace_retire_reader: a reference model tracks counters
// and state, a queue scoreboard holds expected FIFO entries in order.
module tb_trace_retire_reader;
    localparam int          DEPTH = 8;
    localparam logic [31:0] HALT  = 32'h00100073;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] instr_W_TR = '0;
    logic        valid_W = 1'b0;
    logic        tr_ready = 1'b0;
    logic        tr_valid;
    logic [31:0] tr_instr;
    logic [31:0] tr_seq;
    logic [31:0] retire_cnt;
    logic [15:0] drop_cnt;
    logic        overflow;
    logic [3:0]  level;
    logic        halted;
    logic        done;

    int checks = 0;
    int errors = 0;

    // model state
    logic [63:0] sb[$];
    int          m_level = 0;
    logic [31:0] m_retire = '0;
    logic [15:0] m_drop = '0;
    logic        m_ovf = 1'b0;
    int          m_state = 0;   // 0 RUN, 1 DRAIN, 2 DONE

    trace_retire_reader #(.DEPTH(DEPTH), .HALT_INSTR(HALT)) dut (
        .clk(clk), .rst(rst), .instr_W_TR(instr_W_TR), .valid_W(valid_W),
        .tr_valid(tr_valid), .tr_ready(tr_ready), .tr_instr(tr_instr),
        .tr_seq(tr_seq), .retire_cnt(retire_cnt), .drop_cnt(drop_cnt),
        .overflow(overflow), .level(level), .halted(halted), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: check head on pops, advance the model, step the edge, then
    // compare every observable against the model.
    task automatic cycle();
        logic        mpop, ev;
        logic [63:0] e;
        chk("tr_valid", {31'b0, tr_valid}, {31'b0, (m_level != 0)});
        if (!rst) begin
            sb.delete();
            m_level = 0; m_retire = '0; m_drop = '0; m_ovf = 1'b0; m_state = 0;
        end else begin
            mpop = (m_level != 0) && tr_ready;
            ev   = valid_W && (instr_W_TR != 0) && (m_state == 0);
            if (mpop) begin
                if (sb.size() == 0) begin
                    chk("sb_empty", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("head_instr", tr_instr, e[63:32]);
                    chk("head_seq", tr_seq, e[31:0]);
                end
                m_level--;
            end
            if (ev) begin
                if (m_level < DEPTH || mpop) begin
                    sb.push_back({instr_W_TR, m_retire});
                    m_level++;
                end else begin
                    m_ovf = 1'b1;
                    if (m_drop != 16'hFFFF) m_drop++;
                end
                m_retire++;
                if (instr_W_TR == HALT) m_state = 1;
            end else if (m_state == 1 && m_level == 0) begin
                m_state = 2;
            end
        end
        @(posedge clk);
        #1;
        chk("level", {28'b0, level}, m_level);
        chk("retire_cnt", retire_cnt, m_retire);
        chk("drop_cnt", {16'b0, drop_cnt}, {16'b0, m_drop});
        chk("overflow", {31'b0, overflow}, {31'b0, m_ovf});
        chk("halted", {31'b0, halted}, {31'b0, (m_state != 0)});
        chk("done", {31'b0, done}, {31'b0, (m_state == 2)});
    endtask

    task automatic ret(input logic [31:0] w);
        valid_W = 1'b1; instr_W_TR = w;
        cycle();
        valid_W = 1'b0; instr_W_TR = '0;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b0;
        for (int i = 0; i < n; i++) cycle();
        rst = 1'b1;
    endtask

    initial begin
        #1;
        // 1: reset then bubbles
        do_reset(2);
        chk("rst_tr_valid", {31'b0, tr_valid}, 32'd0);
        valid_W = 1'b1; instr_W_TR = '0; tr_ready = 1'b1;
        for (int i = 0; i < 5; i++) cycle();
        valid_W = 1'b0;
        chk("bubble_level", {28'b0, level}, 32'd0);
        chk("bubble_retire", retire_cnt, 32'd0);

        // 2: basic ordering with reader ready
        ret(32'h00000013);
        chk("t2_visible", {31'b0, tr_valid}, 32'd1);
        chk("t2_first_seq", tr_seq, 32'd0);
        ret(32'h00500093);
        ret(32'h00A00113);
        for (int i = 0; i < 3; i++) cycle();
        chk("t2_retire", retire_cnt, 32'd3);
        chk("t2_sb_left", sb.size(), 32'd0);

        // 3: overflow
        do_reset(1);
        tr_ready = 1'b0;
        for (int i = 0; i < 10; i++) ret(32'h00000013 + (i << 20));
        chk("t3_level", {28'b0, level}, 32'd8);
        chk("t3_drop", {16'b0, drop_cnt}, 32'd2);
        chk("t3_ovf", {31'b0, overflow}, 32'd1);
        chk("t3_retire", retire_cnt, 32'd10);
        tr_ready = 1'b1;
        for (int i = 0; i < 9; i++) cycle();
        chk("t3_drained", {28'b0, level}, 32'd0);

        // 4: full plus simultaneous pop
        do_reset(1);
        tr_ready = 1'b0;
        for (int i = 0; i < 8; i++) ret(32'h10000000 + i);
        tr_ready = 1'b1;
        ret(32'hDEADBEEF);
        chk("t4_level", {28'b0, level}, 32'd8);
        chk("t4_drop", {16'b0, drop_cnt}, 32'd0);
        for (int i = 0; i < 9; i++) cycle();
        chk("t4_sb_left", sb.size(), 32'd0);

        // 5: halt and drain
        do_reset(1);
        tr_ready = 1'b0;
        ret(32'h00000013);
        ret(HALT);
        chk("t5_halted", {31'b0, halted}, 32'd1);
        ret(32'h00500093);
        chk("t5_retire", retire_cnt, 32'd2);
        tr_ready = 1'b1;
        cycle();
        chk("t5_not_done", {31'b0, done}, 32'd0);
        cycle();
        tr_ready = 1'b0;
        chk("t5_done", {31'b0, done}, 32'd1);
        cycle();
        chk("t5_done_hold", {31'b0, done}, 32'd1);

        // 6: reset mid-drain
        do_reset(1);
        ret(32'h00000013);
        ret(32'h00500093);
        ret(HALT);
        chk("t6_level3", {28'b0, level}, 32'd3);
        do_reset(1);
        chk("t6_level0", {28'b0, level}, 32'd0);
        chk("t6_halted0", {31'b0, halted}, 32'd0);
        ret(32'h00A00113);
        chk("t6_seq0", tr_seq, 32'd0);
        tr_ready = 1'b1;
        cycle();
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
